// File: rtl/uart_pkg.sv
// Shared constants, state encodings and frame-length helper for the parametrised UART.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    // Total bits on the wire for one transmitted frame, start bit included.
    function automatic int frame_bits(input int data_width, input int parity_mode,
                                      input int stop_bits);
        return 1 + data_width + ((parity_mode != PARITY_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter that pulses tick for one cycle at zero and then
// reloads itself to a full bit period.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 8,
    localparam int W = $clog2(CLKS_PER_BIT)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tick
);

    localparam logic [W-1:0] FULL = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= FULL;
        end else if (load) begin
            count <= load_val;
        end else if (count == '0) begin
            count <= FULL;
        end else begin
            count <= count - 1'b1;
        end
    end

    assign tick = (count == '0);

endmodule

// File: rtl/uart_param.sv
// Parametrised full-duplex UART: TX and RX state machines, input synchroniser
// and parity logic, with one bit timer per direction.
module uart_param
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int PARITY_MODE  = 1,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 8,
    parameter int NUM_RX_SYNC  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_busy,
    output logic                  serial_out,
    input  logic                  serial_in,
    output logic [DATA_WIDTH-1:0] received_data,
    output logic                  data_is_valid,
    output logic                  parity_error,
    output logic                  framing_error,
    output tx_state_t             tx_state,
    output rx_state_t             rx_state
);

    localparam int           TW       = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] FULL_BIT = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_BIT = TW'(CLKS_PER_BIT / 2 - 1);
    localparam bit           HAS_PAR  = (PARITY_MODE != PARITY_NONE);
    localparam logic [3:0]   LAST_BIT = 4'(DATA_WIDTH - 1);
    localparam logic [3:0]   LAST_STP = 4'(STOP_BITS - 1);

    // Handshake: enable acts as valid and ~o_busy as ready; a payload is taken
    // only on a cycle where both are high, otherwise enable is simply dropped.

    logic                  tx_load, tx_tick, tx_par;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [3:0]            tx_cnt;
    logic                  tx_par_calc;

    assign tx_load     = (tx_state == TX_IDLE) && enable;
    assign tx_par_calc = (PARITY_MODE == PARITY_ODD) ? ~^i_data : ^i_data;

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tx_load),
        .load_val (FULL_BIT),
        .tick     (tx_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state   <= TX_IDLE;
            serial_out <= 1'b1;
            o_busy     <= 1'b0;
            tx_shift   <= '0;
            tx_par     <= 1'b0;
            tx_cnt     <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: if (enable) begin
                    tx_shift   <= i_data;
                    tx_par     <= tx_par_calc;
                    serial_out <= 1'b0;
                    o_busy     <= 1'b1;
                    tx_state   <= TX_START;
                end
                TX_START: if (tx_tick) begin
                    serial_out <= tx_shift[0];
                    tx_shift   <= tx_shift >> 1;
                    tx_cnt     <= '0;
                    tx_state   <= TX_DATA;
                end
                TX_DATA: if (tx_tick) begin
                    if (tx_cnt == LAST_BIT) begin
                        tx_cnt <= '0;
                        if (HAS_PAR) begin
                            serial_out <= tx_par;
                            tx_state   <= TX_PARITY;
                        end else begin
                            serial_out <= 1'b1;
                            tx_state   <= TX_STOP;
                        end
                    end else begin
                        serial_out <= tx_shift[0];
                        tx_shift   <= tx_shift >> 1;
                        tx_cnt     <= tx_cnt + 1'b1;
                    end
                end
                TX_PARITY: if (tx_tick) begin
                    serial_out <= 1'b1;
                    tx_state   <= TX_STOP;
                end
                TX_STOP: if (tx_tick) begin
                    if (tx_cnt == LAST_STP) begin
                        o_busy   <= 1'b0;
                        tx_state <= TX_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // Synchroniser resets to the idle line level so reset never looks like a start edge.
    logic [NUM_RX_SYNC-1:0] sync;
    logic                   s;

    always_ff @(posedge clk) begin
        if (reset) sync <= '1;
        else       sync <= {sync[NUM_RX_SYNC-2:0], serial_in};
    end

    assign s = sync[NUM_RX_SYNC-1];

    logic                  rx_load, rx_tick, rx_par_err, rx_par_exp;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic [3:0]            rx_cnt;

    assign rx_load    = (rx_state == RX_IDLE) && !s;
    assign rx_par_exp = (PARITY_MODE == PARITY_ODD) ? ~^rx_shift : ^rx_shift;

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (rx_load),
        .load_val (HALF_BIT),
        .tick     (rx_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state      <= RX_IDLE;
            rx_shift      <= '0;
            rx_cnt        <= '0;
            rx_par_err    <= 1'b0;
            received_data <= '0;
            data_is_valid <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            data_is_valid <= 1'b0;
            case (rx_state)
                RX_IDLE: if (!s) rx_state <= RX_START;
                RX_START: if (rx_tick) begin
                    rx_cnt     <= '0;
                    rx_par_err <= 1'b0;
                    rx_state   <= s ? RX_IDLE : RX_DATA;
                end
                RX_DATA: if (rx_tick) begin
                    rx_shift <= {s, rx_shift[DATA_WIDTH-1:1]};
                    if (rx_cnt == LAST_BIT) rx_state <= HAS_PAR ? RX_PARITY : RX_STOP;
                    else                    rx_cnt   <= rx_cnt + 1'b1;
                end
                RX_PARITY: if (rx_tick) begin
                    rx_par_err <= (s != rx_par_exp);
                    rx_state   <= RX_STOP;
                end
                // Only the first stop bit is sampled so back-to-back frames are accepted.
                RX_STOP: if (rx_tick) begin
                    received_data <= rx_shift;
                    parity_error  <= rx_par_err;
                    framing_error <= !s;
                    data_is_valid <= 1'b1;
                    rx_state      <= s ? RX_IDLE : RX_WAIT_HIGH;
                end
                RX_WAIT_HIGH: if (s) rx_state <= RX_IDLE;
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_param.sv
// Scoreboarded bench: a default-parameter UART (loopback or driven line) and a
// 7-bit odd-parity two-stop-bit UART in loopback.
module tb_uart_param;
    import uart_pkg::*;

    localparam int CPB = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Default-parameter instance
    logic       enable0 = 1'b0;
    logic [7:0] i_data0 = '0;
    logic       busy0, serial_out0, dv0, pe0, fe0;
    logic [7:0] rd0;
    tx_state_t  tx_st0;
    rx_state_t  rx_st0;
    logic       loop_en = 1'b1;
    logic       line = 1'b1;
    logic       serial_in0;
    assign serial_in0 = loop_en ? serial_out0 : line;

    uart_param dut0 (
        .clk(clk), .reset(reset), .enable(enable0), .i_data(i_data0),
        .o_busy(busy0), .serial_out(serial_out0), .serial_in(serial_in0),
        .received_data(rd0), .data_is_valid(dv0), .parity_error(pe0),
        .framing_error(fe0), .tx_state(tx_st0), .rx_state(rx_st0)
    );

    // 7-bit, odd parity, two stop bits, loopback
    logic       enable7 = 1'b0;
    logic [6:0] i_data7 = '0;
    logic       busy7, serial_out7, dv7, pe7, fe7;
    logic [6:0] rd7;
    tx_state_t  tx_st7;
    rx_state_t  rx_st7;

    uart_param #(.DATA_WIDTH(7), .PARITY_MODE(2), .STOP_BITS(2),
                 .CLKS_PER_BIT(CPB), .NUM_RX_SYNC(3)) dut7 (
        .clk(clk), .reset(reset), .enable(enable7), .i_data(i_data7),
        .o_busy(busy7), .serial_out(serial_out7), .serial_in(serial_out7),
        .received_data(rd7), .data_is_valid(dv7), .parity_error(pe7),
        .framing_error(fe7), .tx_state(tx_st7), .rx_state(rx_st7)
    );

    int tests = 0;
    int fails = 0;
    int pulses = 0;

    // Expected RX results packed as {framing_error, parity_error, data}
    logic [9:0] exp_q[$];
    int         exp_cyc_q[$];
    logic [8:0] exp7_q[$];
    int         exp7_cyc_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitors
    always @(negedge clk) begin : mon0
        logic [9:0] e;
        int         ec;
        if (dv0 === 1'b1) begin
            pulses++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rx0_unexpected: got pulse data=%0h pe=%0b fe=%0b, expected none (cycle %0d)",
                         rd0, pe0, fe0, cyc);
            end else begin
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                check("rx0_frame", {22'd0, fe0, pe0, rd0}, {22'd0, e});
                if (ec >= 0) check("rx0_latency", cyc, ec);
            end
        end
    end

    always @(negedge clk) begin : mon7
        logic [8:0] e;
        int         ec;
        if (dv7 === 1'b1) begin
            if (exp7_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rx7_unexpected: got pulse data=%0h, expected none (cycle %0d)", rd7, cyc);
            end else begin
                e  = exp7_q.pop_front();
                ec = exp7_cyc_q.pop_front();
                check("rx7_frame", {23'd0, fe7, pe7, rd7}, {23'd0, e});
                check("rx7_latency", cyc, ec);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected to have finished", cyc);
        $fatal(1, "watchdog");
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Called at a negedge; returns the cycle e in which enable was high.
    task automatic send_tx0(input logic [7:0] d, input logic [9:0] exp, input int lat, output int e);
        e = cyc;
        enable0 = 1'b1;
        i_data0 = d;
        exp_q.push_back(exp);
        exp_cyc_q.push_back(e + lat);
        @(negedge clk);
        enable0 = 1'b0;
    endtask

    task automatic send_raw(input logic [7:0] d, input logic par);
        line = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            line = d[i];
            repeat (CPB) @(negedge clk);
        end
        line = par;
        repeat (CPB) @(negedge clk);
        line = 1'b1;
        repeat (4 * CPB) @(negedge clk);
    endtask

    localparam int FRAME0 = 11;
    localparam int LAT0   = 2 + 3 + CPB / 2 + (8 + 1 + 1) * CPB;
    localparam int LAT7   = 2 + 3 + CPB / 2 + (7 + 1 + 1) * CPB;

    initial begin : main
        int  e, e2, p;
        logic exp_bits [11];
        exp_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

        // Reset state
        repeat (4) @(negedge clk);
        check("rst_serial_out", serial_out0, 1'b1);
        check("rst_busy", busy0, 1'b0);
        check("rst_dv", dv0, 1'b0);
        check("rst_pe", pe0, 1'b0);
        check("rst_fe", fe0, 1'b0);
        check("rst_rd", rd0, 8'h00);
        check("rst_serial_out7", serial_out7, 1'b1);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Loopback A5 while hammering enable with changing data during the frame
        check("frame_len_fn", frame_bits(8, 1, 1), FRAME0);
        send_tx0(8'hA5, {2'b00, 8'hA5}, LAT0, e);
        check("tx_busy_rise", busy0, 1'b1);
        check("tx_start_bit", serial_out0, 1'b0);
        enable0 = 1'b1;
        while (cyc < e + 80) begin
            i_data0 = 8'($urandom_range(0, 255));
            @(negedge clk);
        end
        enable0 = 1'b0;
        wait_until(e + FRAME0 * CPB);
        check("tx_busy_last_stop", busy0, 1'b1);
        check("tx_stop_level", serial_out0, 1'b1);
        wait_until(e + FRAME0 * CPB + 1);
        check("tx_busy_fall", busy0, 1'b0);
        // Back-to-back: new enable in the same cycle busy falls
        send_tx0(8'h0F, {2'b00, 8'h0F}, LAT0, e2);
        check("tx_b2b_busy", busy0, 1'b1);
        wait_until(e2 + 100);

        // 7-bit odd parity, two stop bits: wire pattern and receive
        e = cyc;
        enable7 = 1'b1;
        i_data7 = 7'h55;
        exp7_q.push_back({2'b00, 7'h55});
        exp7_cyc_q.push_back(e + LAT7);
        @(negedge clk);
        enable7 = 1'b0;
        i_data7 = 7'h2A;
        for (int k = 0; k < 11; k++) begin
            wait_until(e + 1 + k * CPB + CPB / 2);
            check($sformatf("tx7_bit%0d", k), serial_out7, exp_bits[k]);
        end
        wait_until(e + frame_bits(7, 2, 2) * CPB);
        check("tx7_busy_last_stop", busy7, 1'b1);
        wait_until(e + frame_bits(7, 2, 2) * CPB + 1);
        check("tx7_busy_fall", busy7, 1'b0);
        repeat (20) @(negedge clk);

        // Directly driven line: 3C with the parity bit flipped (correct even parity is 0)
        line = 1'b1;
        loop_en = 1'b0;
        repeat (4) @(negedge clk);
        exp_q.push_back({2'b01, 8'h3C});
        exp_cyc_q.push_back(-1);
        send_raw(8'h3C, 1'b1);

        // Break: 40 bit periods low gives exactly one framing-error pulse
        p = pulses;
        exp_q.push_back({2'b10, 8'h00});
        exp_cyc_q.push_back(-1);
        line = 1'b0;
        repeat (40 * CPB) @(negedge clk);
        check("break_one_pulse", pulses, p + 1);
        check("break_fe_held", fe0, 1'b1);
        line = 1'b1;
        repeat (50) @(negedge clk);
        check("break_no_more", pulses, p + 1);
        // Recovery frame 96: four ones, even parity 0
        exp_q.push_back({2'b00, 8'h96});
        exp_cyc_q.push_back(-1);
        send_raw(8'h96, 1'b0);

        // False start: low for CPB/2-1 cycles
        p = pulses;
        line = 1'b0;
        repeat (CPB / 2 - 1) @(negedge clk);
        line = 1'b1;
        repeat (120) @(negedge clk);
        check("false_start", pulses, p);

        // Reset mid-frame (bit 4 of a TX frame) with a simultaneous enable
        loop_en = 1'b1;
        repeat (4) @(negedge clk);
        p = pulses;
        e = cyc;
        enable0 = 1'b1;
        i_data0 = 8'h5A;
        @(negedge clk);
        enable0 = 1'b0;
        wait_until(e + 1 + 5 * CPB + 4);
        reset = 1'b1;
        enable0 = 1'b1;
        i_data0 = 8'h77;
        @(negedge clk);
        check("midrst_serial_out", serial_out0, 1'b1);
        check("midrst_busy", busy0, 1'b0);
        check("midrst_dv", dv0, 1'b0);
        check("midrst_rd", rd0, 8'h00);
        reset = 1'b0;
        enable0 = 1'b0;
        repeat (150) @(negedge clk);
        check("midrst_no_pulse", pulses, p);
        check("midrst_busy_after", busy0, 1'b0);
        send_tx0(8'hC3, {2'b00, 8'hC3}, LAT0, e);
        wait_until(e + FRAME0 * CPB + 1);
        check("post_rst_busy_fall", busy0, 1'b0);
        repeat (40) @(negedge clk);

        check("exp_q_drained", exp_q.size(), 0);
        check("exp7_q_drained", exp7_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_param.md
# uart_param

Parametrised full-duplex UART, successor to the fixed 8-bit even-parity UART: data width, parity mode (none/even/odd), stop-bit count, bit period and synchroniser depth are all parameters. The receiver reports parity and framing errors separately and handles false starts and break conditions. The transmitter latches its payload on `enable`. The block sits between the system clock domain and an asynchronous serial line, and is verified in TX-to-RX loopback.

## Interface
- `DATA_WIDTH`, 8: payload bits per frame, 5..9.
- `PARITY_MODE`, 1: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: transmitted stop bits, 1 or 2.
- `CLKS_PER_BIT`, 8: clk cycles per bit; even and ≥4.
- `NUM_RX_SYNC`, 3: flip-flop stages on `serial_in`, ≥2.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high; wins over every other input.
- `enable`  in  1  TX request; honoured only when `o_busy`=0.
- `i_data`  in  DATA_WIDTH  TX payload; sampled on an accepted `enable`.
- `o_busy`  out  1  TX frame in progress.
- `serial_out`  out  1  TX line; idle high.
- `serial_in`  in  1  asynchronous RX line.
- `received_data`  out  DATA_WIDTH  last received payload; holds until the next frame.
- `data_is_valid`  out  1  one-cycle pulse per completed RX frame.
- `parity_error`  out  1  parity mismatch; valid with `data_is_valid`.
- `framing_error`  out  1  first stop bit sampled low; valid with `data_is_valid`.

## Operation
Constants:
- P = (PARITY_MODE≠0); FRAME = 1+DATA_WIDTH+P+STOP_BITS bits.
- Parity bit = ^data for even, ~^data for odd.

Reset values:
- `serial_out`=1.
- `o_busy`, `data_is_valid`, `parity_error`, `framing_error` = 0.
- `received_data`=0.
- Synchroniser stages = 1; both state machines IDLE.

TX FSM (IDLE → START → DATA → PARITY (skipped if P=0) → STOP → IDLE):
- `enable` in IDLE latches `i_data` into the shift register and starts the bit timer.
- Data is sent LSB first; each bit lasts exactly CLKS_PER_BIT cycles.
- Parity is computed from the latched copy, so `i_data` may change freely after acceptance.
- STOP lasts STOP_BITS×CLKS_PER_BIT cycles.
- `enable` while busy is ignored; it is neither queued nor an error.

RX FSM (IDLE → START → DATA → PARITY (skipped if P=0) → STOP → IDLE, plus WAIT_HIGH). Let s = synchroniser output.
- IDLE: on s=0, load the timer with CLKS_PER_BIT/2.
- START: at the timer tick, re-sample s. If s=1, it was a false start → IDLE with no pulse and no flags. If s=0, reload the timer with CLKS_PER_BIT.
- DATA and PARITY: sample once per CLKS_PER_BIT at mid-bit.
- STOP: only the first stop bit is sampled. The receiver accepts back-to-back frames with one stop bit regardless of the STOP_BITS setting.
- At the stop sample, register `received_data`, `parity_error` and `framing_error`, and pulse `data_is_valid` on the next cycle.
- If s=0 at the stop sample (break or framing fault): set `framing_error` and go to WAIT_HIGH. WAIT_HIGH returns to IDLE only after s=1. A sustained break yields exactly one error pulse.
- Error flags hold their value until the next `data_is_valid`.

## Timing
- Accepted `enable` at cycle e:
  - `o_busy`=1 and `serial_out`=0 from e+1.
  - Last stop-bit cycle is e+FRAME×CLKS_PER_BIT.
  - `o_busy`=0 at e+FRAME×CLKS_PER_BIT+1; a new `enable` may be accepted in that same cycle.
- RX latency: s follows `serial_in` by NUM_RX_SYNC cycles.
- Loopback: `data_is_valid` is high at cycle e+2+NUM_RX_SYNC+CLKS_PER_BIT/2+(DATA_WIDTH+P+1)×CLKS_PER_BIT. With all defaults this is e+89.
- Reset mid-frame: all outputs take their reset values on the next cycle and any partial frame is discarded.
- A frame whose start edge is interrupted by reset is not reported.
- Simultaneous `enable` and `reset`: reset wins; `o_busy` stays 0.

## Structure
- Shared package `uart_pkg` holds:
  - PARITY_NONE, PARITY_EVEN and PARITY_ODD constants;
  - TX and RX state encodings;
  - a function returning FRAME from the parameters.
- Sub-module `uart_bit_timer` is instantiated once for TX and once for RX. It is a loadable down-counter of width $clog2(CLKS_PER_BIT) that emits a one-cycle `tick` at zero.
- The synchroniser, both FSMs and the parity logic are inline in `uart_param`.

## Test plan
- Defaults in loopback: `enable` with `i_data`=8'hA5 at cycle e → `data_is_valid` at e+89, `received_data`=8'hA5, both error flags 0, `o_busy` falls at e+89.
- DATA_WIDTH=7, PARITY_MODE=2, STOP_BITS=2: send 7'h55 → `serial_out` shows 0,1010101 (LSB first), parity 1, then 1,1; received 7'h55 with no errors.
- Drive `serial_in` directly with the parity bit flipped on 8'h3C → `data_is_valid`, `received_data`=8'h3C, `parity_error`=1.
- Hold `serial_in` low for 40 bit periods → exactly one `data_is_valid` pulse with `framing_error`=1 and `received_data`=0; no further pulses until the line returns high and a new frame arrives.
- False start and busy behaviour:
  - `serial_in` low for CLKS_PER_BIT/2−1 cycles, then high → no pulse.
  - `enable` asserted while `o_busy`=1 with `i_data` changing → only the first payload is transmitted.
- Reset mid-frame: assert `reset` at bit 4 of a TX frame → next cycle `serial_out`=1 and `o_busy`=0; no `data_is_valid`; the next frame is received correctly.
